burst_ram: RTL and testbench
============================

# burst_ram

Behavioural and synthesizable burst-mode RAM: the downstream consumer of the cache front end's `br_` bus. It accepts read/write burst commands and stores data in an on-chip array of `BURST_DATA_BITWIDTH`-wide words. It streams read bursts back after a fixed latency and drives `br_busy` so the caches serialize their accesses. It stands in for the external burst-RAM controller in simulation and in FPGA builds without external memory.

## Interface
- `DEPTH_BITWIDTH`, 4: address width; array holds 2^DEPTH_BITWIDTH words.
- `BURST_DATA_BITWIDTH`, 64: width of one beat or word.
- `BURST_COUNT`, 4: beats per burst. Minimum 1, maximum 2^DEPTH_BITWIDTH.
- `READ_LATENCY`, 4: cycles from command acceptance to the first read beat. Minimum 2.
- `WRITE_RECOVERY`, 2: idle cycles after the last write beat before the next command is accepted. Minimum 0.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `br_cmd` input 1: 0 = read, 1 = write.
- `br_cmd_en` input 1: command strobe.
- `br_addr` input DEPTH_BITWIDTH: word address of the first beat.
- `br_wr_data` input BURST_DATA_BITWIDTH: write beat.
- `br_data_mask` input BURST_DATA_BITWIDTH/8: per-byte mask; 1 = byte not written.
- `br_rd_data` output BURST_DATA_BITWIDTH: read beat. Registered; reset value 0.
- `br_rd_data_valid` output 1: marks a valid read beat. Reset value 0.
- `br_busy` output 1: high while a command is in progress. Reset value 0.

## Operation
- States: IDLE, READ_WAIT, READ_BURST, WRITE_BURST, WRITE_RECOVER.
- IDLE:
  - `br_cmd_en`=1 with `br_cmd`=0 → READ_WAIT.
  - `br_cmd_en`=1 with `br_cmd`=1 → WRITE_BURST, or WRITE_RECOVER if BURST_COUNT=1.
  - On acceptance, `br_addr` is latched into the beat pointer.
- `br_cmd_en` outside IDLE is ignored: no queueing and no error.
- Beat address:
  - Beat i of a burst uses address `latched_addr + i`, modulo 2^DEPTH_BITWIDTH. Wrap-around is legal.
  - Unaligned start addresses are legal.
- READ_WAIT:
  - The latency counter counts to READ_LATENCY-1.
  - Array reads are issued early enough that beat 0 appears registered on the first READ_BURST cycle.
  - Then → READ_BURST.
- READ_BURST:
  - Emits BURST_COUNT consecutive beats with `br_rd_data_valid`=1.
  - Then → IDLE.
  - `br_rd_data` holds its last value when not valid.
- WRITE_BURST:
  - Beat 0 is taken from `br_wr_data`/`br_data_mask` in the acceptance cycle (in IDLE).
  - Beats 1..BURST_COUNT-1 are taken on the following cycles, one per cycle, with no gaps.
  - Then → WRITE_RECOVER.
- WRITE_RECOVER:
  - Waits WRITE_RECOVERY cycles, then → IDLE.
  - With WRITE_RECOVERY=0 it passes through in zero cycles: straight to IDLE.
- Counters are sized `$clog2(max(READ_LATENCY, BURST_COUNT, WRITE_RECOVERY)+1)`.
- Reset mid-operation:
  - State → IDLE; counters cleared; all outputs go to their reset values.
  - Array contents are not cleared.
  - A write burst interrupted by reset leaves the beats already written in place.

## Timing
- Command accepted at cycle T (IDLE and `br_cmd_en`=1).
- Read burst:
  - `br_busy`=1 in cycles T+1 .. T+READ_LATENCY+BURST_COUNT-1.
  - Valid beats in cycles T+READ_LATENCY .. T+READ_LATENCY+BURST_COUNT-1.
  - `br_busy`=0 at T+READ_LATENCY+BURST_COUNT, and a new command is accepted in that cycle.
- Write burst:
  - Beat i is sampled at T+i.
  - `br_busy`=1 in cycles T+1 .. T+BURST_COUNT-1+WRITE_RECOVERY.
  - `br_busy`=0 at T+BURST_COUNT+WRITE_RECOVERY.
- `br_busy` is 0 in cycle T itself. The cache side must not re-strobe in T+1; it gates on the registered `br_busy`.
- Data written by a burst is visible to any read accepted afterwards.

## Configuration
- `BURST_RAM_WRITE_MASK_EN` defined:
  - `br_data_mask` is honoured per byte.
  - Masked bytes keep their previous contents.
- `BURST_RAM_WRITE_MASK_EN` not defined:
  - `br_data_mask` is ignored.
  - Every write beat writes the full word.
  - The array is built as a plain word-write memory.

## Structure
- Package `burst_ram_pkg` holds:
  - `CMD_READ`=0 and `CMD_WRITE`=1.
  - The state encodings, one-hot, 5 bits.
- One sub-module, `burst_ram_array`:
  - Single-port synchronous array with registered read.
  - Byte-enable write when `BURST_RAM_WRITE_MASK_EN` is defined.
  - Contains no control logic.

## Test plan
- Reset then idle:
  - Assert `rst` asynchronously mid-cycle → outputs 0 immediately.
  - Release → `br_busy`=0 and `br_rd_data_valid`=0.
- Write then read:
  - Write addr 0x4, beats 0x1111..., 0x2222..., 0x3333..., 0x4444..., mask 0.
  - Read addr 0x4 → four valid beats in the same order.
  - First valid beat exactly 4 cycles after acceptance; `br_busy` low at T+8.
- Wrap-around:
  - Write addr 0xE with 4 beats → lands in words 0xE, 0xF, 0x0, 0x1.
  - Read addr 0xE returns the same sequence.
- Byte mask, with `BURST_RAM_WRITE_MASK_EN`:
  - Word 0 holds 0xFFFF_FFFF_FFFF_FFFF.
  - Write 0 with mask 0xF0 on beat 0 → read gives 0xFFFF_FFFF_0000_0000.
  - Without the macro, the same stimulus reads 0.
- Busy rejection:
  - Read strobe at T, then write strobes at T+1..T+7 → all ignored.
  - Array unchanged; exactly 4 valid beats.
- Reset mid-burst:
  - `rst` at the 2nd read beat → valid drops immediately and no further beats appear.
  - A fresh read returns the previously written data intact.

Source files
------------

// File: rtl/burst_ram_pkg.sv
// Shared command codes, one-hot FSM encodings and sizing helper for burst_ram.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [4:0] {
        IDLE          = 5'b00001,
        READ_WAIT     = 5'b00010,
        READ_BURST    = 5'b00100,
        WRITE_BURST   = 5'b01000,
        WRITE_RECOVER = 5'b10000
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Single-port synchronous word array with registered read; byte-enable writes
// only when BURST_RAM_WRITE_MASK_EN is defined, plain word writes otherwise.
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH      = 4,
    parameter int BURST_DATA_BITWIDTH = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [DEPTH_BITWIDTH-1:0]      addr,
    input  logic [BURST_DATA_BITWIDTH-1:0] wdata,
`ifdef BURST_RAM_WRITE_MASK_EN
    input  logic [BURST_DATA_BITWIDTH/8-1:0] byte_en,
`endif
    output logic [BURST_DATA_BITWIDTH-1:0] rdata
);

    logic [BURST_DATA_BITWIDTH-1:0] mem [2**DEPTH_BITWIDTH];

`ifdef BURST_RAM_WRITE_MASK_EN
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BURST_DATA_BITWIDTH/8; b++) begin
                if (byte_en[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end
`else
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
`endif

endmodule

// File: rtl/burst_ram.sv
// Burst-mode RAM behind the cache br_ bus: fixed-latency read bursts, gapless
// write bursts with recovery. Define BURST_RAM_WRITE_MASK_EN to honour br_data_mask.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH      = 4,
    parameter int BURST_DATA_BITWIDTH = 64,
    parameter int BURST_COUNT         = 4,
    parameter int READ_LATENCY        = 4,
    parameter int WRITE_RECOVERY      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             br_cmd,
    input  logic                             br_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]        br_addr,
    input  logic [BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    input  logic [BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    output logic [BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    output logic                             br_rd_data_valid,
    output logic                             br_busy
);

    localparam int CNT_W = $clog2(max3(READ_LATENCY, BURST_COUNT, WRITE_RECOVERY) + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] BC_LAST = CNT_W'(BURST_COUNT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_RECOVERY);
    localparam logic [DEPTH_BITWIDTH-1:0] ADDR_ONE = DEPTH_BITWIDTH'(1);
    localparam int ISSUE_FIRST = READ_LATENCY - 2;

    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [DEPTH_BITWIDTH-1:0]      ptr;
    logic                           accept;
    logic                           accept_rd;
    logic                           accept_wr;
    logic                           rd_issue_p0;
    logic                           rd_vld_p1;
    logic                           mem_we;
    logic [DEPTH_BITWIDTH-1:0]      mem_addr;
    logic [BURST_DATA_BITWIDTH-1:0] rd_data_p1;

    assign accept    = (state == IDLE) && br_cmd_en;
    assign accept_rd = accept && (br_cmd == CMD_READ);
    assign accept_wr = accept && (br_cmd == CMD_WRITE);

    // Beat i is read from the array at acceptance + READ_LATENCY-2+i so that the
    // array register plus the output register land it exactly on its beat cycle.
    always_comb begin
        rd_issue_p0 = 1'b0;
        case (state)
            IDLE:       rd_issue_p0 = accept_rd && (READ_LATENCY == 2);
            READ_WAIT:  rd_issue_p0 = (int'(cnt) >= ISSUE_FIRST) &&
                                      (int'(cnt) < ISSUE_FIRST + BURST_COUNT);
            READ_BURST: rd_issue_p0 = (int'(cnt) + 2 < BURST_COUNT);
            default:    rd_issue_p0 = 1'b0;
        endcase
    end

    assign mem_we   = accept_wr || (state == WRITE_BURST);
    assign mem_addr = (state == IDLE) ? br_addr : ptr;

    burst_ram_array #(
        .DEPTH_BITWIDTH      (DEPTH_BITWIDTH),
        .BURST_DATA_BITWIDTH (BURST_DATA_BITWIDTH)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .addr    (mem_addr),
        .wdata   (br_wr_data),
`ifdef BURST_RAM_WRITE_MASK_EN
        .byte_en (~br_data_mask),
`endif
        .rdata   (rd_data_p1)
    );

`ifndef BURST_RAM_WRITE_MASK_EN
    logic unused_mask;
    assign unused_mask = ^br_data_mask;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            br_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= CNT_ONE;
                        ptr     <= br_addr + DEPTH_BITWIDTH'(accept_wr || rd_issue_p0);
                        br_busy <= 1'b1;
                        if (accept_rd) begin
                            state <= READ_WAIT;
                        end else if (BURST_COUNT > 1) begin
                            state <= WRITE_BURST;
                        end else if (WRITE_RECOVERY > 0) begin
                            state <= WRITE_RECOVER;
                        end else begin
                            state   <= IDLE;
                            cnt     <= '0;
                            br_busy <= 1'b0;
                        end
                    end
                end
                READ_WAIT: begin
                    if (rd_issue_p0) ptr <= ptr + ADDR_ONE;
                    if (cnt == RL_LAST) begin
                        state <= READ_BURST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                READ_BURST: begin
                    if (rd_issue_p0) ptr <= ptr + ADDR_ONE;
                    if (cnt == BC_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        br_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WRITE_BURST: begin
                    ptr <= ptr + ADDR_ONE;
                    if (cnt == BC_LAST) begin
                        if (WRITE_RECOVERY > 0) begin
                            state <= WRITE_RECOVER;
                            cnt   <= CNT_ONE;
                        end else begin
                            state   <= IDLE;
                            cnt     <= '0;
                            br_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WRITE_RECOVER: begin
                    if (cnt >= WR_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        br_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    br_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: array data registered onto br_rd_data, held between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1        <= 1'b0;
            br_rd_data_valid <= 1'b0;
            br_rd_data       <= '0;
        end else begin
            rd_vld_p1        <= rd_issue_p0;
            br_rd_data_valid <= rd_vld_p1;
            if (rd_vld_p1) br_rd_data <= rd_data_p1;
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: cycle-indexed reference model plus
// hand-computed expectations for latency, wrap-around, masking, busy and reset.
module tb_burst_ram;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int BC = 4;
    localparam int RL = 4;
    localparam int WR = 2;
    localparam int NC = 4096;
`ifdef BURST_RAM_WRITE_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            br_cmd = 1'b0;
    logic            br_cmd_en = 1'b0;
    logic [AW-1:0]   br_addr = '0;
    logic [DW-1:0]   br_wr_data = '0;
    logic [DW/8-1:0] br_data_mask = '0;
    logic [DW-1:0]   br_rd_data;
    logic            br_rd_data_valid;
    logic            br_busy;

    int tests = 0;
    int fails = 0;

    burst_ram #(
        .DEPTH_BITWIDTH      (AW),
        .BURST_DATA_BITWIDTH (DW),
        .BURST_COUNT         (BC),
        .READ_LATENCY        (RL),
        .WRITE_RECOVERY      (WR)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: memory image plus per-cycle expected valid/data/busy.
    logic [DW-1:0] mmem [16];
    bit            exp_vld [NC];
    logic [DW-1:0] exp_dat [NC];
    int            cyc = 0;
    int            busy_from = 0;
    int            free_at = 0;
    int            wr_t = 0;
    logic [AW-1:0] wr_base = '0;
    bit            wr_act = 1'b0;
    logic [DW-1:0] hold = '0;
    bit            check_en = 1'b0;
    logic [DW-1:0] ed;
    bit            ev;
    bit            eb;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [DW/8-1:0] m);
        logic [DW-1:0] keep;
        keep = '0;
        for (int b = 0; b < DW/8; b++) keep[b*8 +: 8] = {8{m[b] & MASK_ON}};
        return (old & keep) | (d & ~keep);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            if (wr_act) begin
                if (cyc - wr_t < BC) begin
                    logic [AW-1:0] a;
                    a = wr_base + AW'(cyc - wr_t);
                    mmem[a] = merge(mmem[a], br_wr_data, br_data_mask);
                end else begin
                    wr_act = 1'b0;
                end
            end
            if (cyc >= free_at && br_cmd_en) begin
                busy_from = cyc + 1;
                if (br_cmd) begin
                    wr_act  = 1'b1;
                    wr_t    = cyc;
                    wr_base = br_addr;
                    mmem[br_addr] = merge(mmem[br_addr], br_wr_data, br_data_mask);
                    free_at = cyc + BC + WR;
                end else begin
                    for (int i = 0; i < BC; i++) begin
                        logic [AW-1:0] a;
                        a = br_addr + AW'(i);
                        exp_vld[cyc + RL + i] = 1'b1;
                        exp_dat[cyc + RL + i] = mmem[a];
                    end
                    free_at = cyc + RL + BC;
                end
            end
        end
        cyc++;
    end

    always @(posedge rst) begin
        for (int i = cyc; i < NC; i++) exp_vld[i] = 1'b0;
        busy_from = 0;
        free_at   = 0;
        wr_act    = 1'b0;
        hold      = '0;
    end

    always @(negedge clk) begin
        ev = exp_vld[cyc];
        ed = ev ? exp_dat[cyc] : hold;
        eb = (cyc >= busy_from) && (cyc < free_at);
        if (check_en) begin
            chk("busy", DW'(br_busy), DW'(eb));
            chk("valid", DW'(br_rd_data_valid), DW'(ev));
            chk("rd_data", br_rd_data, ed);
        end
        hold = ed;
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (br_busy && n < 40) begin
            step();
            n++;
        end
        chk("idle_timeout", DW'(br_busy), '0);
    endtask

    task automatic send(input bit cmd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW/8-1:0] m);
        br_cmd       = cmd;
        br_cmd_en    = 1'b1;
        br_addr      = a;
        br_wr_data   = d;
        br_data_mask = m;
        step();
        br_cmd_en = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic [DW-1:0] d3, input logic [DW/8-1:0] m0);
        send(1'b1, a, d0, m0);
        br_data_mask = '0;
        br_wr_data = d1;
        step();
        br_wr_data = d2;
        step();
        br_wr_data = d3;
        step();
        wait_idle();
    endtask

    logic [DW-1:0] cap_d [12];
    bit            cap_v [12];
    bit            cap_b [12];

    // Index k of the capture arrays is cycle acceptance+k.
    task automatic read_capture(input logic [AW-1:0] a);
        send(1'b0, a, '0, '0);
        for (int k = 1; k < 12; k++) begin
            cap_v[k] = br_rd_data_valid;
            cap_d[k] = br_rd_data;
            cap_b[k] = br_busy;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int nv;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        check_en = 1'b1;
        chk("rst_busy", DW'(br_busy), '0);
        chk("rst_valid", DW'(br_rd_data_valid), '0);
        chk("rst_data", br_rd_data, '0);
        step();

        // Write then read at address 4.
        write_burst(4'h4, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}}, '0);
        read_capture(4'h4);
        chk("lat_busy_t1", DW'(cap_b[1]), 64'd1);
        chk("lat_valid_t3", DW'(cap_v[3]), '0);
        chk("lat_valid_t4", DW'(cap_v[4]), 64'd1);
        chk("beat0", cap_d[4], {4{16'h1111}});
        chk("beat1", cap_d[5], {4{16'h2222}});
        chk("beat2", cap_d[6], {4{16'h3333}});
        chk("beat3", cap_d[7], {4{16'h4444}});
        chk("busy_t7", DW'(cap_b[7]), 64'd1);
        chk("busy_t8", DW'(cap_b[8]), '0);
        chk("valid_t8", DW'(cap_v[8]), '0);
        chk("hold_t9", cap_d[9], {4{16'h4444}});

        // Wrap-around from 0xE.
        write_burst(4'hE, {4{16'hA0A0}}, {4{16'hB0B0}}, {4{16'hC0C0}}, {4{16'hD0D0}}, '0);
        read_capture(4'hE);
        chk("wrap_beat0", cap_d[4], {4{16'hA0A0}});
        chk("wrap_beat2", cap_d[6], {4{16'hC0C0}});
        chk("wrap_beat3", cap_d[7], {4{16'hD0D0}});

        // Byte mask on beat 0.
        write_burst(4'h0, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, {DW{1'b1}}, '0);
        write_burst(4'h0, '0, '0, '0, '0, 8'hF0);
        read_capture(4'h0);
        chk("mask_beat0", cap_d[4], MASK_ON ? 64'hFFFF_FFFF_0000_0000 : 64'h0);
        chk("mask_beat1", cap_d[5], 64'h0);

        // Write strobes while a read is in progress are ignored.
        br_cmd = 1'b0;
        br_cmd_en = 1'b1;
        br_addr = 4'h4;
        step();
        br_cmd = 1'b1;
        br_wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        nv = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) br_cmd_en = 1'b0;
            nv += int'(br_rd_data_valid);
            step();
        end
        chk("busy_rej_beats", DW'(nv), 64'd4);
        wait_idle();
        read_capture(4'h4);
        chk("busy_rej_beat0", cap_d[4], {4{16'h1111}});
        chk("busy_rej_beat3", cap_d[7], {4{16'h4444}});

        // Reset asserted at the second read beat.
        send(1'b0, 4'h4, '0, '0);
        repeat (4) step();
        chk("pre_rst_valid", DW'(br_rd_data_valid), 64'd1);
        chk("pre_rst_data", br_rd_data, {4{16'h2222}});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", DW'(br_rd_data_valid), '0);
        chk("async_rst_data", br_rd_data, '0);
        chk("async_rst_busy", DW'(br_busy), '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            nv += int'(br_rd_data_valid);
        end
        chk("post_rst_beats", DW'(nv), '0);
        read_capture(4'h4);
        chk("post_rst_beat0", cap_d[4], {4{16'h1111}});
        chk("post_rst_beat3", cap_d[7], {4{16'h4444}});

        repeat (3) step();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
